// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: word layout, halt opcode
// and the fetch FSM state encoding.
package instr_fetch_queue_pkg;

    localparam int INSTR_W = 24;
    localparam int FIELD_W = 8;
    localparam int OP_LSB = 16;
    localparam int OPND1_LSB = 8;
    localparam int OPND2_LSB = 0;

    localparam logic [FIELD_W-1:0] HALT_OP_DEF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ifq_state_e;

    function automatic logic [FIELD_W-1:0] field(input logic [INSTR_W-1:0] word, input int lsb);
        return word[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Instruction delivery channel between the fetch queue (master) and the processor (slave).
interface instr_fetch_queue_if;
    // valid/ready: a transfer happens on a rising edge where instr_valid and instr_ready are
    // both 1; while instr_valid=1 and instr_ready=0 the master holds the instruction fields
    // stable; instr_ready has no effect while instr_valid=0; fields read 0 when not valid.
    logic [7:0] opcode;
    logic [7:0] operand1;
    logic [7:0] operand2;
    logic       instr_valid;
    logic       instr_ready;

    modport master (
        output opcode, operand1, operand2, instr_valid,
        input  instr_ready
    );

    modport slave (
        input  opcode, operand1, operand2, instr_valid,
        output instr_ready
    );

endinterface

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted
// when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Loadable program memory plus sequential fetcher feeding a FIFO that delivers
// one instruction per handshake until a halt opcode or the end of memory.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int                 MEM_DEPTH  = 16,
    parameter int                 ADDR_W     = 4,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [FIELD_W-1:0] HALT_OP    = HALT_OP_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [INSTR_W-1:0]  prog_data,
    instr_fetch_queue_if.master ifq,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                done,
    output ifq_state_e          state_dbg
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [INSTR_W-1:0] mem [MEM_DEPTH];
    logic [INSTR_W-1:0] word;
    logic [INSTR_W-1:0] head;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push;
    logic               fetch_en;
    logic               is_halt;
    logic               last_addr;
    logic               drain_empty;
    ifq_state_e         state;

    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign word        = mem[pc];
    assign is_halt     = (field(word, OP_LSB) == HALT_OP);
    assign last_addr   = (pc == ADDR_W'(MEM_DEPTH - 1));
    assign pop         = ifq.instr_valid && ifq.instr_ready;
    assign fetch_en    = (state == ST_FETCH) && (!full || pop);
    assign push        = fetch_en && !is_halt;
    assign drain_empty = (count == '0) || ((count == CNT_W'(1)) && pop);

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (word),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign ifq.instr_valid = !empty;
    assign ifq.opcode      = field(head, OP_LSB);
    assign ifq.operand1    = field(head, OPND1_LSB);
    assign ifq.operand2    = field(head, OPND2_LSB);
    assign state_dbg       = state;

    // busy/done are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            pc    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_FETCH;
                        pc    <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (fetch_en) begin
                        if (is_halt || last_addr) begin
                            state <= ST_DRAIN;
                        end else begin
                            pc <= pc + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_empty) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: program loads, handshake delivery,
// back-pressure, end-of-memory stop, busy write protection, reset and halt-at-0.
module tb_instr_fetch_queue;
    import instr_fetch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [23:0] prog_data;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    ifq_state_e  state_dbg;

    instr_fetch_queue_if bus ();

    instr_fetch_queue dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .ifq       (bus),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          valid_cnt = 0;
    logic [23:0] exp_q[$];
    logic [23:0] model_mem[16];
    logic [23:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [23:0] d, input bit update_model);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
        if (update_model) model_mem[a] = d;
    endtask

    // Queue the instructions the program should deliver, then pulse start for one edge.
    task automatic pulse_start();
        for (int a = 0; a < 16; a++) begin
            if (model_mem[a][23:16] == 8'hFF) break;
            exp_q.push_back(model_mem[a]);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (reset && bus.instr_valid) begin
            valid_cnt++;
            if (bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_pop", 32'd0, 32'd1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("sb_word", {8'd0, bus.opcode, bus.operand1, bus.operand2}, {8'd0, mon_exp});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] w;
        bit          saw_drain;
        int          n;

        reset           = 1'b0;
        start           = 1'b0;
        prog_we         = 1'b0;
        prog_addr       = '0;
        prog_data       = '0;
        bus.instr_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_opcode", {24'd0, bus.opcode}, 32'd0);
        check("rst_opnd", {16'd0, bus.operand1, bus.operand2}, 32'd0);
        check("rst_pc", {28'd0, pc}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
        reset = 1'b1;
        tick();

        // 1: short program with halt at address 2
        write_word(4'd0, 24'h010503, 1'b1);
        write_word(4'd1, 24'h020A04, 1'b1);
        write_word(4'd2, 24'hFF0000, 1'b1);
        bus.instr_ready = 1'b1;
        valid_cnt = 0;
        pulse_start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_valid_lat0", {31'd0, bus.instr_valid}, 32'd0);
        tick();
        check("t1_valid_lat1", {31'd0, bus.instr_valid}, 32'd1);
        wait_done("t1", 50);
        check("t1_valid_cycles", valid_cnt, 32'd2);
        check("t1_sb_empty", exp_q.size(), 32'd0);
        check("t1_pc", {28'd0, pc}, 32'd2);
        check("t1_busy_end", {31'd0, busy}, 32'd0);

        // 2: back-pressure with 6 words then halt
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            w = 24'h102030 + 24'h010101 * 24'(i);
            write_word(4'(i), w, 1'b1);
        end
        write_word(4'd6, 24'hFF0000, 1'b1);
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_head_stable", {8'd0, bus.opcode, bus.operand1, bus.operand2}, 32'h102030);
        end
        check("t2_count", {29'd0, dut.u_fifo.count}, 32'd4);
        check("t2_pc", {28'd0, pc}, 32'd4);
        check("t2_busy", {31'd0, busy}, 32'd1);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("t2_nogap", {31'd0, bus.instr_valid}, 32'd1);
            tick();
        end
        wait_done("t2", 50);
        check("t2_sb_empty", exp_q.size(), 32'd0);

        // 3: full 16-word program without halt
        for (int i = 0; i < 16; i++) begin
            w = 24'h400102 + 24'h010203 * 24'(i);
            write_word(4'(i), w, 1'b1);
        end
        valid_cnt = 0;
        pulse_start();
        saw_drain = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            if (state_dbg == ST_DRAIN) saw_drain = 1'b1;
            tick();
            n++;
        end
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_saw_drain", {31'd0, saw_drain}, 32'd1);
        check("t3_valid_cycles", valid_cnt, 32'd16);
        check("t3_pc", {28'd0, pc}, 32'd15);
        check("t3_sb_empty", exp_q.size(), 32'd0);
        repeat (3) tick();
        check("t3_no_wrap_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("t3_no_wrap_pc", {28'd0, pc}, 32'd15);

        // 4: program write while busy is ignored
        bus.instr_ready = 1'b0;
        pulse_start();
        tick();
        tick();
        check("t4_busy", {31'd0, busy}, 32'd1);
        write_word(4'd1, 24'hAAAAAA, 1'b0);
        bus.instr_ready = 1'b1;
        wait_done("t4a", 100);
        check("t4a_sb_empty", exp_q.size(), 32'd0);
        pulse_start();
        wait_done("t4b", 100);
        check("t4b_sb_empty", exp_q.size(), 32'd0);

        // 5: asynchronous reset with 3 entries queued
        bus.instr_ready = 1'b0;
        pulse_start();
        repeat (3) tick();
        check("t5_count", {29'd0, dut.u_fifo.count}, 32'd3);
        reset = 1'b0;
        #1;
        check("t5_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("t5_fields", {8'd0, bus.opcode, bus.operand1, bus.operand2}, 32'd0);
        check("t5_pc", {28'd0, pc}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
        exp_q.delete();
        tick();
        reset = 1'b1;
        tick();
        bus.instr_ready = 1'b1;
        pulse_start();
        wait_done("t5", 100);
        check("t5_sb_empty", exp_q.size(), 32'd0);

        // 6: halt at address 0
        write_word(4'd0, 24'hFF0000, 1'b1);
        valid_cnt = 0;
        pulse_start();
        check("t6_done_n0", {31'd0, done}, 32'd0);
        tick();
        check("t6_done_n1", {31'd0, done}, 32'd0);
        check("t6_state_n1", {30'd0, state_dbg}, {30'd0, ST_DRAIN});
        tick();
        check("t6_done_n2", {31'd0, done}, 32'd1);
        check("t6_state_n2", {30'd0, state_dbg}, {30'd0, ST_DONE});
        check("t6_valid_never", valid_cnt, 32'd0);
        check("t6_sb_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Upstream stage of the processor core. It holds a small loadable program memory of 24-bit instruction words {opcode, operand1, operand2}. It fetches sequentially from that memory into a FIFO and presents one instruction at a time to the processor over a valid/ready handshake. It replaces the free-running instruction loader with back-pressure-aware, halt-terminated delivery.

Parameters:
MEM_DEPTH, 16, number of program words (power of two)
ADDR_W, 4, log2(MEM_DEPTH)
FIFO_DEPTH, 4, instruction queue entries (power of two, >= 2)
HALT_OP, 8'hFF, opcode that terminates fetch

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  begin fetching from address 0; sampled only in IDLE or DONE
prog_we  in  1  program-memory write strobe; honoured only when busy=0
prog_addr  in  ADDR_W  program write address
prog_data  in  24  program word {opcode[23:16], operand1[15:8], operand2[7:0]}
opcode  out  8  head instruction opcode
operand1  out  8  head instruction operand 1
operand2  out  8  head instruction operand 2
instr_valid  out  1  head of queue holds a valid instruction
instr_ready  in  1  processor accepts head this cycle
pc  out  ADDR_W  next address to fetch
busy  out  1  state is FETCH or DRAIN
done  out  1  state is DONE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low.
- Reset values: state=IDLE, pc=0, FIFO empty (rd/wr ptr=0, count=0), instr_valid=0, opcode/operand1/operand2=0, busy=0, done=0. Program memory is not reset; its contents survive reset.
- Program write: on a clk edge with prog_we=1 and busy=0, mem[prog_addr]<=prog_data. With busy=1 the write is ignored.
- FSM states:
  - IDLE: start=1 -> FETCH, pc<=0.
  - FETCH: each edge with a free slot (count<FIFO_DEPTH, or a pop occurs the same cycle), read mem[pc].
    - If the word's opcode==HALT_OP: the word is not pushed; -> DRAIN.
    - Else push the word and pc<=pc+1.
    - If the pushed word came from pc==MEM_DEPTH-1: -> DRAIN. No wrap-around; pc holds at MEM_DEPTH-1.
  - DRAIN: no fetches. When count reaches 0 (including via a pop this cycle) -> DONE.
  - DONE: done=1 and holds. start=1 -> FETCH with pc<=0 and done<=0.
- Latency: start sampled at edge N. First push at edge N+1; instr_valid=1 after edge N+1. Throughput is 1 instruction/cycle when instr_ready is held high.
- Handshake:
  - A pop occurs on an edge where instr_valid=1 and instr_ready=1.
  - Head outputs stay stable while instr_valid=1 and instr_ready=0.
  - Outputs read 0 when the queue is empty.
  - instr_ready while instr_valid=0 has no effect.
- Simultaneous push and pop: count unchanged. This is permitted even when full, which gives full throughput.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is ADDR-independent, width log2(FIFO_DEPTH)+1.
- start while busy: ignored.
- Reset mid-operation: immediate return to IDLE; queued instructions are discarded.
- HALT_OP at address 0: no push; IDLE->FETCH->DRAIN->DONE. done=1 two edges after start is sampled, and instr_valid never asserts.

Decomposition:
- Shared package: FSM state encoding (IDLE, FETCH, DRAIN, DONE), the instruction-word field offsets, and the HALT_OP default.
- One sub-module: sync_fifo, parameterised by width (24) and depth, with push/pop/full/empty/count. The FSM and program memory stay in the top.

Test Plan:
1. Load 0x01_05_03, 0x02_0A_04, 0xFF_00_00 at addresses 0..2; pulse start; instr_ready=1 -> instr_valid high for exactly 2 cycles, presenting (01,05,03) then (02,0A,04); done=1 after the queue empties; pc=2.
2. Back-pressure: 6 non-halt words then halt; hold instr_ready=0 for 10 cycles -> count saturates at 4, pc=4, head stays (word 0), busy=1; release instr_ready -> all 6 words delivered in order with no gaps, then done.
3. No-halt program filling all 16 words, instr_ready=1 -> 16 instructions delivered, pc holds 15, state DRAIN then DONE; no wrap back to address 0.
4. Attempt prog_we to address 1 with data 0xAA_AA_AA while busy -> memory unchanged; rerun yields the original word at address 1.
5. Assert reset low mid-FETCH with 3 entries queued -> instr_valid=0, outputs 0, pc=0, busy=0 immediately; after release and start, the program replays from address 0.
6. HALT_OP at address 0; pulse start -> done=1 two edges after start is sampled, instr_valid never asserts.
